// File: rtl/key_conditioner.sv
// key_conditioner
//   Synchronizes and debounces four active-low pushbuttons and synchronizes
//   ten slide switches. Each key has its own four-state debounce FSM.
//   The FSM emits registered press/release pulses and a debounced level.
//
//   Optional feature: define KEY_CONDITIONER_AUTO_REPEAT_EN to add per-key
//   auto-repeat. A key held in PRESSED emits extra key_press pulses,
//   REPEAT_DELAY cycles after entry and then every REPEAT_RATE cycles.
//
// Ports
//   clock        in   1   board clock, all state on rising edge
//   reset        in   1   asynchronous active-high reset
//   key          in   4   raw pushbuttons, active-low, asynchronous
//   sw           in  10   raw slide switches, asynchronous
//   key_level    out  4   debounced key state, 1 = pressed
//   key_press    out  4   one-cycle pulse per accepted press (and per repeat)
//   key_release  out  4   one-cycle pulse per accepted release
//   sw_sync      out 10   switches after a two-flop synchronizer
module key_conditioner #(
  parameter int unsigned STABLE_CYCLES = 240000,
  parameter int unsigned REPEAT_DELAY  = 12000000,
  parameter int unsigned REPEAT_RATE   = 2400000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key,
  input  logic [9:0] sw,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [9:0] sw_sync
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [3:0]    key_s1;
  logic [3:0]    key_s2;
  logic [9:0]    sw_s1;
  state_t        state [4];
  logic [CW-1:0] cnt   [4];

`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW      = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_C = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RATE_C  = RW'(REPEAT_RATE);

  // rpt_first selects the initial delay; after the first repeat the
  // shorter rate period applies until the key leaves PRESSED for good.
  logic [RW-1:0] rpt_cnt   [4];
  logic [3:0]    rpt_first;
`else
  // Repeat timing parameters have no effect in this build.
  if (REPEAT_DELAY == 0 || REPEAT_RATE == 0) begin : g_repeat_unused
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1      <= '1;
      key_s2      <= '1;
      sw_s1       <= '0;
      sw_sync     <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
        rpt_cnt[i] <= '0;
`endif
      end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
      rpt_first <= '1;
`endif
    end else begin
      key_s1  <= key;
      key_s2  <= key_s1;
      sw_s1   <= sw;
      sw_sync <= sw_s1;

      key_press   <= '0;
      key_release <= '0;

      for (int unsigned i = 0; i < 4; i++) begin
        case (state[i])
          IDLE: begin
            if (!key_s2[i]) begin
              state[i] <= PRESS_WAIT;
              cnt[i]   <= ONE_C;
            end
          end

          PRESS_WAIT: begin
            if (key_s2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == STABLE_C) begin
              state[i]     <= PRESSED;
              key_press[i] <= 1'b1;
              key_level[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + ONE_C;
            end
          end

          PRESSED: begin
            if (key_s2[i]) begin
              state[i] <= RELEASE_WAIT;
              cnt[i]   <= ONE_C;
            end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
            else if ((rpt_cnt[i] + RW'(1)) == (rpt_first[i] ? DELAY_C : RATE_C)) begin
              key_press[i]  <= 1'b1;
              rpt_cnt[i]    <= '0;
              rpt_first[i]  <= 1'b0;
            end else begin
              rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
            end
`endif
          end

          RELEASE_WAIT: begin
            // A bounce back to PRESSED keeps the repeat counter as it was.
            if (!key_s2[i]) begin
              state[i] <= PRESSED;
            end else if (cnt[i] == STABLE_C) begin
              state[i]       <= IDLE;
              cnt[i]         <= '0;
              key_release[i] <= 1'b1;
              key_level[i]   <= 1'b0;
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
              rpt_cnt[i]   <= '0;
              rpt_first[i] <= 1'b1;
`endif
            end else begin
              cnt[i] <= cnt[i] + ONE_C;
            end
          end

          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int unsigned S = 4;
  localparam int unsigned LAT = 2 + S;  // edges from first low sample to pulse

  logic       clock;
  logic       reset;
  logic [3:0] key;
  logic [9:0] sw;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [9:0] sw_sync;

  key_conditioner #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (20),
    .REPEAT_RATE  (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key        (key),
    .sw         (sw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .sw_sync    (sw_sync)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] exp_level = '0;
  logic [9:0] sw_p1 = '0;
  logic [9:0] sw_p2 = '0;

  // Edge counter plus a two-stage delay line of the switch inputs.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      sw_p1 = '0;
      sw_p2 = '0;
    end else begin
      sw_p2 = sw_p1;
      sw_p1 = sw;
    end
  end

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.level = l;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  always begin
    ev_t e;
    @(posedge clock);
    #2;
    if (reset) begin
      checks++;
      if ({key_level, key_press, key_release, sw_sync} != '0) begin
        errors++;
        $display("FAIL reset_zero cyc=%0d got lvl=%b prs=%b rel=%b sw=%h want all zero",
                 cyc, key_level, key_press, key_release, sw_sync);
      end
      exp_level = '0;
    end else begin
      checks++;
      if (sw_sync != sw_p2) begin
        errors++;
        $display("FAIL sw_sync cyc=%0d got %h want %h", cyc, sw_sync, sw_p2);
      end
      if ((key_press | key_release) != '0) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got prs=%b rel=%b want none",
                   cyc, key_press, key_release);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.press != key_press || e.rel != key_release) begin
            errors++;
            $display("FAIL pulse got cyc=%0d prs=%b rel=%b want cyc=%0d prs=%b rel=%b",
                     cyc, key_press, key_release, e.cyc, e.press, e.rel);
          end
          exp_level = e.level;
        end
      end
      checks++;
      if (key_level != exp_level) begin
        errors++;
        $display("FAIL key_level cyc=%0d got %b want %b", cyc, key_level, exp_level);
      end
    end
  end

  int p;

  initial begin
    reset = 1'b1;
    key   = 4'b1111;
    sw    = '0;

    // Release reset after edge 3; switches follow with two cycles of delay.
    while (cyc != 3) @(negedge clock);
    reset = 1'b0;
    sw = 10'h2A5;

    // Single key press sampled at edge 10 -> pulse after edge 16.
    while (cyc != 9) @(negedge clock);
    key = 4'b1011;
    push(16, 4'b0100, 4'b0000, 4'b0100);
    step(10);
    key = 4'b1111;
    push(cyc + 1 + LAT, 4'b0000, 4'b0100, 4'b0000);
    step(12);

    // Glitch of 3 cycles on key[0] is rejected.
    sw = 10'h15A;
    key = 4'b1110;
    step(3);
    key = 4'b1111;
    step(12);

    // Held key[1] with a 2-cycle release bounce: no extra pulses.
    key = 4'b1101;
    push(cyc + 1 + LAT, 4'b0010, 4'b0000, 4'b0010);
    step(10);
    key = 4'b1111;
    step(2);
    key = 4'b1101;
    step(10);
    key = 4'b1111;
    push(cyc + 1 + LAT, 4'b0000, 4'b0010, 4'b0000);
    step(12);

    // All keys together.
    sw = 10'h3FF;
    key = 4'b0000;
    push(cyc + 1 + LAT, 4'b1111, 4'b0000, 4'b1111);
    step(10);
    key = 4'b1111;
    push(cyc + 1 + LAT, 4'b0000, 4'b1111, 4'b0000);
    step(12);

    // Reset two cycles into PRESS_WAIT with the key held; the first edge
    // after deassertion samples the held key, so full latency follows it.
    key = 4'b1011;
    step(4);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    push(cyc + 1 + LAT, 4'b0100, 4'b0000, 4'b0100);
    step(10);
    key = 4'b1111;
    push(cyc + 1 + LAT, 4'b0000, 4'b0100, 4'b0000);
    step(12);

    // Long hold on key[2]: release sampled at acceptance+39.
    sw = 10'h001;
    key = 4'b1011;
    p = cyc + 1 + LAT;
    push(p, 4'b0100, 4'b0000, 4'b0100);
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
    push(p + 20, 4'b0100, 4'b0000, 4'b0100);
    push(p + 25, 4'b0100, 4'b0000, 4'b0100);
    push(p + 30, 4'b0100, 4'b0000, 4'b0100);
    push(p + 35, 4'b0100, 4'b0000, 4'b0100);
    push(p + 40, 4'b0100, 4'b0000, 4'b0100);
`endif
    while (cyc != p + 38) @(negedge clock);
    key = 4'b1111;
    push(p + 45, 4'b0000, 4'b0100, 4'b0000);
    step(15);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got %0d outstanding want 0 (next due cyc=%0d)",
               q.size(), q[0].cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter STABLE_CYCLES, default 240000, is the number of consecutive stable clock samples required to accept a key level change (10 ms at 24 MHz); legal range 2..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 12000000, is the number of cycles a key must be held before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 2400000, is the number of cycles between subsequent auto-repeat pulses.
REQ-004 The design has one clock; reset is asynchronous and active-high.
REQ-005 clock  input  1  board clock, all state on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 key  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous to clock.
REQ-008 sw  input  10  raw slide switches, asynchronous to clock.
REQ-009 key_level  output  4  debounced key state, active-high (1 = pressed).
REQ-010 key_press  output  4  one-cycle pulse per accepted press (and per repeat, see REQ-029).
REQ-011 key_release  output  4  one-cycle pulse per accepted release.
REQ-012 sw_sync  output  10  switches after a two-flop synchronizer.

Function
REQ-013 Each key bit and sw bit SHALL pass through its own two-flop synchronizer before any other logic.
REQ-014 Each key SHALL have an independent FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus its own counter of ceil(log2(STABLE_CYCLES+1)) bits.
REQ-015 IDLE: synchronized key = 0 -> PRESS_WAIT with counter cleared to 1; otherwise stay.
REQ-016 PRESS_WAIT: synchronized key = 1 -> IDLE, with no pulse emitted; otherwise counter increments; on reaching STABLE_CYCLES -> PRESSED.
REQ-017 PRESS_WAIT -> PRESSED transition SHALL assert key_press[i] for exactly the one cycle in which the state register first reads PRESSED; key_level[i] rises in that same cycle.
REQ-018 PRESSED: synchronized key = 1 -> RELEASE_WAIT with counter cleared to 1; otherwise stay.
REQ-019 RELEASE_WAIT: synchronized key = 0 -> PRESSED, with no pulse emitted; otherwise counter increments; on reaching STABLE_CYCLES -> IDLE, with key_release[i] pulsing for one cycle and key_level[i] falling in that cycle.
REQ-020 Latency: a clean raw press sampled low at edge N SHALL produce key_press at the output after edge N+2+STABLE_CYCLES (two synchronizer cycles plus STABLE_CYCLES counting cycles); release latency is identical.
REQ-021 key_level[i] = 1 in PRESSED and RELEASE_WAIT and 0 in IDLE and PRESS_WAIT.
REQ-022 Counters SHALL saturate and never wrap; no glitch shorter than STABLE_CYCLES SHALL change key_level.
REQ-023 Keys are fully independent; simultaneous presses on several keys SHALL produce simultaneous pulses on the corresponding bits.
REQ-024 key_press and key_release for the same key SHALL never be high in the same cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While reset = 1: key synchronizer flops = 1, sw synchronizer flops = 0, all FSMs = IDLE, all counters = 0, key_level = 0, key_press = 0, key_release = 0, sw_sync = 0.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard that progress; after deassertion a key already held low SHALL take the full REQ-020 latency to be accepted.

Configuration
REQ-028 The macro KEY_CONDITIONER_AUTO_REPEAT_EN compiles the auto-repeat feature in or out.
REQ-029 With the macro defined: while in PRESSED, a per-key repeat counter SHALL emit an extra key_press pulse REPEAT_DELAY cycles after entry, then every REPEAT_RATE cycles; the repeat counter SHALL clear on leaving PRESSED and SHALL pause in RELEASE_WAIT; a bounce returning RELEASE_WAIT -> PRESSED SHALL resume it without clearing.
REQ-030 Without the macro: key_press SHALL pulse exactly once per accepted press, no repeat counters SHALL exist, and REPEAT_DELAY and REPEAT_RATE SHALL be ignored.

Verification (STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-031 key[2] is driven low at edge 10 and held -> key_press[2] is high only after edge 16, key_level[2] rises in that cycle, and other bits stay 0.
REQ-032 key[0] is driven low for 3 cycles then high -> key_press[0], key_level[0] and key_release[0] all stay 0.
REQ-033 A held key[1] is released for 2 cycles then pressed again -> there are no release or press pulses and key_level[1] stays 1 throughout.
REQ-034 key[3:0] is driven to 0000 at one edge -> key_press = 1111 for one cycle; releasing all keys together gives key_release = 1111 for one cycle, 6 cycles after the release.
REQ-035 Reset is asserted 2 cycles into PRESS_WAIT with the key held, then deasserted -> key_press occurs exactly 2+4 cycles after deassertion, and all outputs are 0 during reset.
REQ-036 With KEY_CONDITIONER_AUTO_REPEAT_EN, key[2] held for 40 cycles after acceptance -> key_press[2] pulses at +0, +20, +25, +30, +35 and +40 cycles; without the macro it pulses at +0 only.
